// File: rtl/alu_ctrl_pkg.sv
// Shared op codes, ALUop/func7 encodings, FSM states and latency classes for the
// registered ALU control decoder (M-extension gated by ALU_CTRL_M_EXT_EN).
package alu_ctrl_pkg;

  localparam logic [4:0] OP_ADD     = 5'd0;
  localparam logic [4:0] OP_SUB     = 5'd1;
  localparam logic [4:0] OP_SLL     = 5'd2;
  localparam logic [4:0] OP_SLT     = 5'd3;
  localparam logic [4:0] OP_SLTU    = 5'd4;
  localparam logic [4:0] OP_XOR     = 5'd5;
  localparam logic [4:0] OP_SRL     = 5'd6;
  localparam logic [4:0] OP_SRA     = 5'd7;
  localparam logic [4:0] OP_OR      = 5'd8;
  localparam logic [4:0] OP_AND     = 5'd9;
  localparam logic [4:0] OP_MUL     = 5'd16;
  localparam logic [4:0] OP_ILLEGAL = 5'd31;

  localparam logic [1:0] ALUOP_LS = 2'b00;
  localparam logic [1:0] ALUOP_BR = 2'b01;
  localparam logic [1:0] ALUOP_R  = 2'b10;
  localparam logic [1:0] ALUOP_I  = 2'b11;

  localparam logic [6:0] FUNC7_BASE = 7'b0000000;
  localparam logic [6:0] FUNC7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNC7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FULL} state_t;
  typedef enum logic [1:0] {LAT_1, LAT_MUL, LAT_DIV} lat_class_t;

  // Base integer op selected by func3 when func7 carries no modifier.
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Decode request / decoded-op handshake bundle between ID/EX and the ALU control block.
// A transfer happens on an edge where valid and ready are both high; valid must not depend on ready.
interface alu_ctrl_if #(parameter int OP_W = 5);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [6:0]      func7;
  logic [2:0]      func3;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] op;
  logic            illegal;
  logic            busy;

  modport master (
    output in_valid, alu_op, func7, func3, out_ready,
    input  in_ready, out_valid, op, illegal, busy
  );

  modport slave (
    input  in_valid, alu_op, func7, func3, out_ready,
    output in_ready, out_valid, op, illegal, busy
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUop/func7/func3 decoder; latency class output exists only
// when ALU_CTRL_M_EXT_EN is defined.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [6:0] func7,
  input  logic [2:0] func3,
`ifdef ALU_CTRL_M_EXT_EN
  output lat_class_t lat,
`endif
  output logic [4:0] op,
  output logic       illegal
);

  always_comb begin
    op = OP_ILLEGAL;
`ifdef ALU_CTRL_M_EXT_EN
    lat = LAT_1;
`endif
    case (alu_op)
      ALUOP_LS: op = OP_ADD;
      ALUOP_BR: op = OP_SUB;
      ALUOP_R: begin
        if (func7 == FUNC7_BASE)                       op = base_op(func3);
        else if (func7 == FUNC7_ALT && func3 == 3'b000) op = OP_SUB;
        else if (func7 == FUNC7_ALT && func3 == 3'b101) op = OP_SRA;
`ifdef ALU_CTRL_M_EXT_EN
        else if (func7 == FUNC7_MEXT) begin
          op  = OP_MUL | {2'b00, func3};
          lat = func3[2] ? LAT_DIV : LAT_MUL;
        end
`endif
      end
      default: begin
        // I-type ignores func7 except where it encodes the shift kind.
        if (func3 == 3'b001) begin
          if (func7 == FUNC7_BASE) op = OP_SLL;
        end else if (func3 == 3'b101) begin
          if (func7 == FUNC7_BASE)     op = OP_SRL;
          else if (func7 == FUNC7_ALT) op = OP_SRA;
        end else begin
          op = base_op(func3);
        end
      end
    endcase
    illegal = (op == OP_ILLEGAL);
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered, handshaked ALU control decoder; multi-cycle MUL/DIV sequencing is
// compiled in when ALU_CTRL_M_EXT_EN is defined.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  alu_ctrl_if.slave   bus,
  output state_t      dbg_state
);

  if (OP_W < 5) begin : g_bad_op_w
    $error("OP_W must be >= 5");
  end
  if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
    $error("MUL_LAT and DIV_LAT must be >= 1");
  end
  if ((1 << CNT_W) <= MUL_LAT || (1 << CNT_W) <= DIV_LAT) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the configured latencies");
  end

  logic [4:0]      dec_op;
  logic            dec_ill;
  state_t          state, state_n;
  logic            in_ready, accept;
  logic [OP_W-1:0] op_q;
  logic            ill_q;

`ifdef ALU_CTRL_M_EXT_EN
  lat_class_t       dec_lat;
  logic [CNT_W-1:0] cnt, cnt_n, lat_cnt;
`endif

  alu_ctrl_dec u_dec (
    .alu_op  (bus.alu_op),
    .func7   (bus.func7),
    .func3   (bus.func3),
`ifdef ALU_CTRL_M_EXT_EN
    .lat     (dec_lat),
`endif
    .op      (dec_op),
    .illegal (dec_ill)
  );

  // flush masks readiness so a killed cycle can never also accept.
  assign in_ready = !flush && (state == ST_IDLE || (state == ST_FULL && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;

`ifdef ALU_CTRL_M_EXT_EN
  always_comb begin
    lat_cnt = '0;
    case (dec_lat)
      LAT_MUL: lat_cnt = CNT_W'(MUL_LAT - 1);
      LAT_DIV: lat_cnt = CNT_W'(DIV_LAT - 1);
      default: lat_cnt = '0;
    endcase
  end
`endif

  always_comb begin
    state_n = state;
`ifdef ALU_CTRL_M_EXT_EN
    cnt_n = cnt;
`endif
    if (flush) begin
      state_n = ST_IDLE;
`ifdef ALU_CTRL_M_EXT_EN
      cnt_n = '0;
`endif
    end else if (accept) begin
      state_n = ST_FULL;
`ifdef ALU_CTRL_M_EXT_EN
      if (lat_cnt != '0) begin
        state_n = ST_WAIT;
        cnt_n   = lat_cnt;
      end
`endif
    end else begin
      case (state)
        ST_FULL: if (bus.out_ready) state_n = ST_IDLE;
`ifdef ALU_CTRL_M_EXT_EN
        ST_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state_n = ST_FULL;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op_q  <= '0;
      ill_q <= 1'b0;
`ifdef ALU_CTRL_M_EXT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_n;
`ifdef ALU_CTRL_M_EXT_EN
      cnt   <= cnt_n;
`endif
      if (accept) begin
        op_q  <= OP_W'(dec_op);
        ill_q <= dec_ill;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == ST_FULL);
  assign bus.op        = op_q;
  assign bus.illegal   = ill_q;
`ifdef ALU_CTRL_M_EXT_EN
  assign bus.busy      = (state == ST_WAIT);
`else
  assign bus.busy      = 1'b0;
`endif
  assign dbg_state     = state;

endmodule
